// File: rtl/systolic_ctrl.sv
// Sequencer for an MxN systolic array: latches W/B, streams skewed operands, captures C.
// Define SYSTOLIC_CTRL_CHECK_EN to build the compare of C against result_exp (pass/mismatch_cnt).
module systolic_ctrl #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ARRAY_W_W  = 2,
   parameter int unsigned ARRAY_W_L  = 5,
   parameter int unsigned ARRAY_A_L  = 2,
   parameter int unsigned DRAIN_CYC  = 1
) (
   input  logic                                           clk,
   input  logic                                           reset_n,
   input  logic                                           start,
   input  logic [ARRAY_W_W*ARRAY_W_L*DATA_WIDTH-1:0]      data_rom_w,
   input  logic [ARRAY_W_L*ARRAY_A_L*DATA_WIDTH-1:0]      data_rom_b,
   input  logic [ARRAY_W_W*ARRAY_A_L*2*DATA_WIDTH-1:0]    result_exp,
   output logic                                           arr_clear,
   output logic [ARRAY_W_W*DATA_WIDTH-1:0]                arr_a,
   output logic [ARRAY_A_L*DATA_WIDTH-1:0]                arr_b,
   output logic                                           arr_valid,
   input  logic [ARRAY_W_W*ARRAY_A_L*2*DATA_WIDTH-1:0]    arr_c,
   output logic [ARRAY_W_W*ARRAY_A_L*2*DATA_WIDTH-1:0]    result,
   output logic                                           busy,
   output logic                                           done,
   output logic                                           pass,
   output logic [7:0]                                     mismatch_cnt
);

   localparam int M        = int'(ARRAY_W_W);
   localparam int K        = int'(ARRAY_W_L);
   localparam int N        = int'(ARRAY_A_L);
   localparam int DW       = int'(DATA_WIDTH);
   localparam int CW       = 2 * DW;
   localparam int FEED_LEN = K + M + N - 2;
   localparam int TW       = $clog2(FEED_LEN + 1);

   localparam logic [TW-1:0] T_LAST     = TW'(FEED_LEN - 1);
   localparam logic [3:0]    DRAIN_LAST = 4'(DRAIN_CYC - 1);

   typedef enum logic [2:0] {StIdle, StClear, StFeed, StDrain, StCheck} state_e;

   state_e                state_q, state_d;
   logic [TW-1:0]         t_q, t_d;
   logic [3:0]            drain_q, drain_d;
   logic                  load;
   logic [M*K*DW-1:0]     w_q;
   logic [K*N*DW-1:0]     b_q;
   logic [M*N*CW-1:0]     result_q;
   logic                  pass_q, pass_d;
   logic [7:0]            mis_q, mis_d;

   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      drain_d = drain_q;
      load    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StClear;
               load    = 1'b1;
            end
         end
         StClear: begin
            state_d = StFeed;
            t_d     = '0;
         end
         StFeed: begin
            if (t_q == T_LAST) begin
               state_d = StDrain;
               drain_d = '0;
            end else begin
               t_d = t_q + TW'(1);
            end
         end
         StDrain: begin
            if (drain_q == DRAIN_LAST) begin
               state_d = StCheck;
            end else begin
               drain_d = drain_q + 4'd1;
            end
         end
         StCheck: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Skew: lane i of arr_a carries W[i][t-i], lane j of arr_b carries B[t-j][j].
   always_comb begin
      int k;
      k         = 0;
      arr_clear = (state_q == StClear);
      arr_valid = (state_q == StFeed);
      busy      = (state_q != StIdle);
      done      = (state_q == StCheck);
      arr_a     = '0;
      arr_b     = '0;
      if (state_q == StFeed) begin
         for (int i = 0; i < M; i++) begin
            k = int'(t_q) - i;
            if (k >= 0 && k < K) begin
               arr_a[(M-1-i)*DW +: DW] = w_q[(M*K-1-(i*K+k))*DW +: DW];
            end
         end
         for (int j = 0; j < N; j++) begin
            k = int'(t_q) - j;
            if (k >= 0 && k < K) begin
               arr_b[(N-1-j)*DW +: DW] = b_q[(K*N-1-(k*N+j))*DW +: DW];
            end
         end
      end
   end

`ifdef SYSTOLIC_CTRL_CHECK_EN
   logic [M*N*CW-1:0] exp_q;

   always_ff @(posedge clk) begin
      if (load) begin
         exp_q <= result_exp;
      end
   end

   always_comb begin
      int cnt;
      cnt = 0;
      for (int e = 0; e < M*N; e++) begin
         if (arr_c[e*CW +: CW] != exp_q[e*CW +: CW]) begin
            cnt++;
         end
      end
      pass_d = (cnt == 0);
      mis_d  = (cnt > 255) ? 8'hff : 8'(cnt);
   end
`else
   logic unused_exp;
   assign unused_exp = ^result_exp;
   assign pass_d     = 1'b0;
   assign mis_d      = '0;
`endif

   always_ff @(posedge clk) begin
      if (load) begin
         w_q <= data_rom_w;
         b_q <= data_rom_b;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         t_q      <= '0;
         drain_q  <= '0;
         result_q <= '0;
         pass_q   <= 1'b0;
         mis_q    <= '0;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         drain_q <= drain_d;
         if (state_q == StCheck) begin
            result_q <= arr_c;
            pass_q   <= pass_d;
            mis_q    <= mis_d;
         end
      end
   end

   assign result       = result_q;
   assign pass         = pass_q;
   assign mismatch_cnt = mis_q;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: behavioural array model driven by arr_a/arr_b, and a scoreboard of
// expected C/pass/mismatch_cnt pushed at start and popped when done pulses.
`timescale 1ns/1ps
module tb_systolic_ctrl;

   localparam int DW       = 8;
   localparam int M        = 2;
   localparam int K        = 5;
   localparam int N        = 2;
   localparam int DRAIN    = 1;
   localparam int CW       = 2 * DW;
   localparam int FEED_LEN = K + M + N - 2;
   localparam int LAT      = 2 + FEED_LEN + DRAIN;

   logic                clk = 1'b0;
   logic                reset_n = 1'b0;
   logic                start = 1'b0;
   logic [M*K*DW-1:0]   data_rom_w = '0;
   logic [K*N*DW-1:0]   data_rom_b = '0;
   logic [M*N*CW-1:0]   result_exp = '0;
   logic                arr_clear;
   logic [M*DW-1:0]     arr_a;
   logic [N*DW-1:0]     arr_b;
   logic                arr_valid;
   logic [M*N*CW-1:0]   arr_c;
   logic [M*N*CW-1:0]   result;
   logic                busy;
   logic                done;
   logic                pass;
   logic [7:0]          mismatch_cnt;

   systolic_ctrl #(
      .DATA_WIDTH(DW),
      .ARRAY_W_W (M),
      .ARRAY_W_L (K),
      .ARRAY_A_L (N),
      .DRAIN_CYC (DRAIN)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .data_rom_w  (data_rom_w),
      .data_rom_b  (data_rom_b),
      .result_exp  (result_exp),
      .arr_clear   (arr_clear),
      .arr_a       (arr_a),
      .arr_b       (arr_b),
      .arr_valid   (arr_valid),
      .arr_c       (arr_c),
      .result      (result),
      .busy        (busy),
      .done        (done),
      .pass        (pass),
      .mismatch_cnt(mismatch_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Output-stationary array: PE(i,j) takes a from the left, b from above, one cycle per hop.
   logic [DW-1:0] pa_q [M][N];
   logic [DW-1:0] pb_q [M][N];
   logic [CW-1:0] acc_q[M][N];

   function automatic logic [DW-1:0] a_in(int i, int j);
      if (j == 0) return arr_a[(M-1-i)*DW +: DW];
      return pa_q[i][j-1];
   endfunction

   function automatic logic [DW-1:0] b_in(int i, int j);
      if (i == 0) return arr_b[(N-1-j)*DW +: DW];
      return pb_q[i-1][j];
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < M; i++) begin
         for (int j = 0; j < N; j++) begin
            if (!reset_n || arr_clear) begin
               pa_q[i][j]  <= '0;
               pb_q[i][j]  <= '0;
               acc_q[i][j] <= '0;
            end else begin
               pa_q[i][j]  <= a_in(i, j);
               pb_q[i][j]  <= b_in(i, j);
               acc_q[i][j] <= acc_q[i][j] + CW'(a_in(i, j)) * CW'(b_in(i, j));
            end
         end
      end
   end

   always_comb begin
      arr_c = '0;
      for (int i = 0; i < M; i++) begin
         for (int j = 0; j < N; j++) begin
            arr_c[(M*N-1-(i*N+j))*CW +: CW] = acc_q[i][j];
         end
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   logic [DW-1:0] w_m  [M][K];
   logic [DW-1:0] b_m  [K][N];
   logic [CW-1:0] exp_m[M][N];

   typedef struct {
      logic [M*N*CW-1:0] c;
      logic              pass;
      logic [7:0]        mis;
      int                start_cyc;
   } sb_entry_t;

   sb_entry_t sb_q[$];

   task automatic set_nominal();
      for (int k = 0; k < K; k++) begin
         w_m[0][k] = DW'(k);
         w_m[1][k] = DW'(8'h0a + k);
         for (int j = 0; j < N; j++) b_m[k][j] = DW'(2 * k + j);
      end
      exp_m[0][0] = 16'h003c;
      exp_m[0][1] = 16'h0046;
      exp_m[1][0] = 16'h0104;
      exp_m[1][1] = 16'h0140;
   endtask

   task automatic apply_inputs();
      for (int i = 0; i < M; i++)
         for (int k = 0; k < K; k++) data_rom_w[(M*K-1-(i*K+k))*DW +: DW] = w_m[i][k];
      for (int k = 0; k < K; k++)
         for (int j = 0; j < N; j++) data_rom_b[(K*N-1-(k*N+j))*DW +: DW] = b_m[k][j];
      for (int i = 0; i < M; i++)
         for (int j = 0; j < N; j++) result_exp[(M*N-1-(i*N+j))*CW +: CW] = exp_m[i][j];
   endtask

   function automatic logic [M*DW-1:0] exp_a(int t);
      logic [M*DW-1:0] r;
      r = '0;
      for (int i = 0; i < M; i++)
         if (t - i >= 0 && t - i < K) r[(M-1-i)*DW +: DW] = w_m[i][t-i];
      return r;
   endfunction

   function automatic logic [N*DW-1:0] exp_b(int t);
      logic [N*DW-1:0] r;
      r = '0;
      for (int j = 0; j < N; j++)
         if (t - j >= 0 && t - j < K) r[(N-1-j)*DW +: DW] = b_m[t-j][j];
      return r;
   endfunction

   // Called at a negedge; returns at the negedge of the CLEAR cycle.
   task automatic pulse_start();
      sb_entry_t ent;
      int        cnt;
      int        sum;
      cnt = 0;
      ent.c = '0;
      for (int i = 0; i < M; i++) begin
         for (int j = 0; j < N; j++) begin
            sum = 0;
            for (int k = 0; k < K; k++) sum += int'(w_m[i][k]) * int'(b_m[k][j]);
            ent.c[(M*N-1-(i*N+j))*CW +: CW] = CW'(sum);
            if (CW'(sum) != exp_m[i][j]) cnt++;
         end
      end
`ifdef SYSTOLIC_CTRL_CHECK_EN
      ent.pass = (cnt == 0);
      ent.mis  = 8'(cnt);
`else
      ent.pass = 1'b0;
      ent.mis  = 8'd0;
`endif
      ent.start_cyc = cyc;
      sb_q.push_back(ent);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_value("idle_timeout", 64'(n < 100), 64'd1);
      repeat (2) @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check_value({tag, "_arr_clear"}, 64'(arr_clear), 64'd0);
      check_value({tag, "_arr_valid"}, 64'(arr_valid), 64'd0);
      check_value({tag, "_arr_a"}, 64'(arr_a), 64'd0);
      check_value({tag, "_arr_b"}, 64'(arr_b), 64'd0);
      check_value({tag, "_result"}, 64'(result), 64'd0);
      check_value({tag, "_busy"}, 64'(busy), 64'd0);
      check_value({tag, "_done"}, 64'(done), 64'd0);
      check_value({tag, "_pass"}, 64'(pass), 64'd0);
      check_value({tag, "_mismatch_cnt"}, 64'(mismatch_cnt), 64'd0);
   endtask

   // Monitor: latency and busy on done; result/pass/mismatch_cnt the cycle after CHECK.
   initial begin
      sb_entry_t cur;
      logic      pending;
      pending = 1'b0;
      forever begin
         @(negedge clk);
         if (pending) begin
            check_value("result", 64'(result), 64'(cur.c));
            check_value("pass", 64'(pass), 64'(cur.pass));
            check_value("mismatch_cnt", 64'(mismatch_cnt), 64'(cur.mis));
            pending = 1'b0;
         end
         if (done === 1'b1) begin
            check_value("busy_at_done", 64'(busy), 64'd1);
            if (sb_q.size() == 0) begin
               check_value("unexpected_done", 64'(done), 64'd0);
            end else begin
               cur = sb_q.pop_front();
               check_value("latency", 64'(cyc - cur.start_cyc), 64'(LAT));
               pending = 1'b1;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      reset_n = 1'b1;
      @(negedge clk);

      // Nominal run with stream observation.
      set_nominal();
      apply_inputs();
      pulse_start();
      check_value("clear_arr_clear", 64'(arr_clear), 64'd1);
      check_value("clear_arr_valid", 64'(arr_valid), 64'd0);
      check_value("clear_busy", 64'(busy), 64'd1);
      for (int t = 0; t < FEED_LEN; t++) begin
         @(negedge clk);
         check_value($sformatf("feed%0d_valid", t), 64'(arr_valid), 64'd1);
         check_value($sformatf("feed%0d_arr_a", t), 64'(arr_a), 64'(exp_a(t)));
         check_value($sformatf("feed%0d_arr_b", t), 64'(arr_b), 64'(exp_b(t)));
      end
      for (int d = 0; d < DRAIN; d++) begin
         @(negedge clk);
         check_value("drain_valid", 64'(arr_valid), 64'd0);
         check_value("drain_streams", 64'({arr_a, arr_b}), 64'd0);
      end
      wait_idle();
      check_value("nominal_result", 64'(result), 64'h003c_0046_0104_0140);

      // One wrong expected element.
      exp_m[1][1] = 16'h0141;
      apply_inputs();
      pulse_start();
      wait_idle();

      // Inputs change after start, start on FEED beat 3 and in CHECK: all ignored.
      set_nominal();
      apply_inputs();
      pulse_start();
      data_rom_w = ~data_rom_w;
      data_rom_b = ~data_rom_b;
      result_exp = ~result_exp;
      repeat (4) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (done !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check_value("done_timeout", 64'(n < 50), 64'd1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_value("start_in_check_busy", 64'(busy), 64'd0);
      repeat (3) @(negedge clk);
      check_value("start_in_check_idle", 64'(busy), 64'd0);
      apply_inputs();

      // Reset for one cycle during DRAIN aborts the run.
      pulse_start();
      repeat (FEED_LEN + 1) @(negedge clk);
      check_value("pre_reset_busy", 64'(busy), 64'd1);
      check_value("pre_reset_valid", 64'(arr_valid), 64'd0);
      reset_n = 1'b0;
      void'(sb_q.pop_back());
      @(negedge clk);
      check_all_zero("mid_reset");
      reset_n = 1'b1;
      repeat (LAT + 2) @(negedge clk);
      check_value("post_reset_idle", 64'(busy), 64'd0);
      pulse_start();
      wait_idle();

      // Random operands: exact expectations, one wrong element, all elements wrong.
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < M; i++)
            for (int k = 0; k < K; k++) w_m[i][k] = DW'($urandom_range(0, 255));
         for (int k = 0; k < K; k++)
            for (int j = 0; j < N; j++) b_m[k][j] = DW'($urandom_range(0, 255));
         for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
               int sum;
               sum = 0;
               for (int k = 0; k < K; k++) sum += int'(w_m[i][k]) * int'(b_m[k][j]);
               exp_m[i][j] = CW'(sum);
               if (r == 2) exp_m[i][j] = ~exp_m[i][j];
            end
         end
         if (r == 1) exp_m[0][1] = exp_m[0][1] ^ 16'h8000;
         apply_inputs();
         pulse_start();
         wait_idle();
      end

      check_value("scoreboard_empty", 64'(sb_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
